// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage program counter.
package pc_pkg;

  // Redirect classes; the numeric order is the priority used for buffering.
  typedef enum logic [1:0] {
    ClsNone    = 2'd0,
    ClsJump    = 2'd1,
    ClsMispred = 2'd2,
    ClsExc     = 2'd3
  } redir_cls_e;

  localparam int unsigned DefAw = 30;

  // Word addresses (byte 0x0000_3034 and 0x0000_4180).
  localparam logic [DefAw-1:0] DefResetVec = 30'h0000_0C0D;
  localparam logic [DefAw-1:0] DefExcVec   = 30'h0000_1060;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with saturating count.
// Push on full overwrites the oldest entry; pop on empty is ignored.
// Pop and push together replace the top entry without changing the count.
module pc_ras #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  top_q;
  logic [CntW-1:0]  cnt_q;
  logic             pop_eff;
  logic [PtrW-1:0]  wr_ptr;
  logic             wr_en;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign top     = mem_q[top_q];
  assign pop_eff = pop & ~empty;

  // Write slot: replace top on pop+push, otherwise the slot above top (wraps modulo Depth).
  always_comb begin
    wr_en  = push & ~clear & ~rst;
    wr_ptr = pop_eff ? top_q : top_q + 1'b1;
  end

  // Pointer and occupancy; clear wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (push && pop_eff) begin
      top_q <= top_q;
      cnt_q <= cnt_q;
    end else if (push) begin
      top_q <= top_q + 1'b1;
      if (!full) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (pop_eff) begin
      top_q <= top_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised next-PC selection and a
// one-entry redirect buffer that holds redirects arriving during a stall.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned    AW        = 30,
  parameter logic [AW-1:0]  RESET_VEC = AW'(DefResetVec),
  parameter logic [AW-1:0]  EXC_VEC   = AW'(DefExcVec),
  parameter int unsigned    RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          exc_valid,
  input  logic          mispred_valid,
  input  logic [AW-1:0] mispred_pc,
  input  logic          jump_valid,
  input  logic [AW-1:0] jump_pc,
  input  logic [AW-1:0] predict_pc,
  input  logic          call_valid,
  input  logic [AW-1:0] call_ret_pc,
  input  logic          ret_valid,
  output logic [AW-1:0] pc_out,
  output logic          pc_valid,
  output logic          redirect_pending
);

  logic [AW-1:0] pc_q, pc_d;
  logic          valid_q;
  redir_cls_e    pend_cls_q, pend_cls_d;
  logic [AW-1:0] pend_tgt_q, pend_tgt_d;

  redir_cls_e    req_cls;
  logic [AW-1:0] req_tgt;
  logic          req_wins;
  logic          redir_taken;
  logic          use_ret;
  logic          ras_clear;
  logic          ret_hit;
  logic [AW-1:0] ras_top;

  // Highest-priority redirect presented this cycle.
  always_comb begin
    req_cls = ClsNone;
    req_tgt = '0;
    if (exc_valid) begin
      req_cls = ClsExc;
      req_tgt = EXC_VEC;
    end else if (mispred_valid) begin
      req_cls = ClsMispred;
      req_tgt = mispred_pc;
    end else if (jump_valid) begin
      req_cls = ClsJump;
      req_tgt = jump_pc;
    end
  end

  // A new redirect beats the buffered one when its class is at least as high.
  assign req_wins = (req_cls != ClsNone) && (req_cls >= pend_cls_q);

  // Next-PC and redirect-buffer selection.
  always_comb begin
    pc_d        = pc_q;
    pend_cls_d  = pend_cls_q;
    pend_tgt_d  = pend_tgt_q;
    redir_taken = 1'b0;
    use_ret     = 1'b0;
    if (stall) begin
      if (req_wins) begin
        pend_cls_d  = req_cls;
        pend_tgt_d  = req_tgt;
        redir_taken = 1'b1;
      end
    end else begin
      pend_cls_d = ClsNone;
      if (req_wins) begin
        pc_d        = req_tgt;
        redir_taken = 1'b1;
      end else if (pend_cls_q != ClsNone) begin
        pc_d = pend_tgt_q;
      end else if (ret_hit) begin
        pc_d    = ras_top;
        use_ret = 1'b1;
      end else begin
        pc_d = predict_pc;
      end
    end
  end

  // Exceptions and mispredicts invalidate speculative call history.
  assign ras_clear = redir_taken && (req_cls >= ClsMispred);

`ifdef PC_RAS_EN
  logic ras_empty;
  logic ras_full;
  logic unused_ras_full;

  assign ret_hit         = ret_valid & ~ras_empty;
  assign unused_ras_full = ras_full;

  pc_ras #(
    .Depth (RAS_DEPTH),
    .Width (AW)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (call_valid & ~stall),
    .pop       (use_ret),
    .clear     (ras_clear),
    .push_data (call_ret_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  logic unused_ras;

  assign ret_hit    = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = ^{call_valid, call_ret_pc, ret_valid, use_ret, ras_clear};
`endif

  // Registered PC state; reset overrides stall and all redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      pend_cls_q <= ClsNone;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= 1'b1;
      pend_cls_q <= pend_cls_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_out           = pc_q;
  assign pc_valid         = valid_q;
  assign redirect_pending = (pend_cls_q != ClsNone);

endmodule
